multi_debouncer: RTL

Parametrised N-channel switch/button debouncer. It replaces single-channel, fixed-3-tick debouncing in the board-I/O layer between raw pad inputs and user logic.
- One shared tick prescaler drives every channel.
- Each channel has a two-flop input synchroniser, a configurable stability count, and registered single-cycle rise/fall event pulses.
- Intended consumers are counters, FSMs and LED demos that need clean levels and edge events from mechanical switches.

---
 rtl/multi_debouncer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multi_debouncer.sv
// ---------------------------------------------------------------------------
// multi_debouncer
//
// N-channel mechanical switch debouncer. A single prescaler produces a
// sampling tick shared by every channel. Each channel synchronises its raw
// pad input through two flops. It then runs a four-state filter FSM that only
// lets the debounced level follow the input after STABLE_TICKS consecutive
// ticks with the new value. Rise and fall events are registered single-cycle
// pulses that line up with the first cycle of the new level.
//
// Parameters
//   TICK_DIV      clock cycles per sampling tick (>= 2)
//   STABLE_TICKS  ticks a new value must hold before the level follows (>= 1)
//   N_CH          number of independent channels (>= 1)
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst    asynchronous, active-high reset
//   i_sw     raw asynchronous switch inputs, one bit per channel
//   o_level  debounced level per channel
//   o_rise   one-cycle pulse coincident with o_level going 0->1
//   o_fall   one-cycle pulse coincident with o_level going 1->0
//   o_tick   prescaler tick, high one cycle in every TICK_DIV
//
// Handshake: none. All outputs are free-running status and event signals
// with no valid/ready flow control; consumers sample them every cycle.
//
// Debug visibility: each channel's FSM state is the enum register
// g_ch[i].state_q. Its filter count is g_ch[i].cnt_q.
// ---------------------------------------------------------------------------
module multi_debouncer #(
    parameter int TICK_DIV     = 1_000_000,
    parameter int STABLE_TICKS = 3,
    parameter int N_CH         = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_sw,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic            o_tick
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    // The encoding keeps the debounced level in bit 1. The decode below still
    // names the states explicitly, so the encoding can change freely.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // Shared tick prescaler: free-running 0..TICK_DIV-1 counter.
    // -----------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic             tick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Decoded from the counter register. Reset forces the count to 0, so the
    // tick is low during reset without needing a separate flop.
    assign tick   = (div_q == DIV_LAST);
    assign o_tick = tick;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser for every channel. The FSMs only ever see sync_q.
    // -----------------------------------------------------------------------
    logic [N_CH-1:0] meta_q;
    logic [N_CH-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_sw;
            sync_q <= meta_q;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel filter FSM and registered edge pulses.
    // -----------------------------------------------------------------------
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        state_t           state_q;
        state_t           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             s;
        logic             rise_d;
        logic             fall_d;
        logic             rise_q;
        logic             fall_q;

        assign s = sync_q[ch];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                state_q <= ZERO;
                cnt_q   <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;

            case (state_q)
                ZERO: begin
                    if (s) begin
                        state_d = WAIT1;
                        cnt_d   = '0;
                    end
                end

                // The reversion check comes before the tick check. A bounce
                // that lands on a tick cycle therefore aborts the wait and
                // does not advance the count.
                WAIT1: begin
                    if (!s) begin
                        state_d = ZERO;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ONE;
                            cnt_d   = '0;
                            rise_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                ONE: begin
                    if (!s) begin
                        state_d = WAIT0;
                        cnt_d   = '0;
                    end
                end

                WAIT0: begin
                    if (s) begin
                        state_d = ONE;
                        cnt_d   = '0;
                    end else if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ZERO;
                            cnt_d   = '0;
                            fall_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end
            endcase
        end

        // The level is decoded straight from the state register, so it cannot
        // glitch. The pulses are registered from the same transition that
        // loads the new state. This makes them coincide with the first cycle
        // of the new level.
        assign o_level[ch] = (state_q == ONE) || (state_q == WAIT0);
        assign o_rise[ch]  = rise_q;
        assign o_fall[ch]  = fall_q;
    end

endmodule
